// File: rtl/mem_pkg.sv
// mem_pkg: shared funct3 encodings and responder state type for the data-memory path.
package mem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;
endpackage

// File: rtl/load_formatter.sv
// load_formatter: picks the byte/half lane of a loaded word and sign- or zero-extends it.
module load_formatter
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    assign w_byte = 8'(i_word >> {i_offset, 3'b000});
    assign w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
    assign o_data = (i_funct3 == F3_B)  ? {{24{w_byte[7]}}, w_byte} :
                    (i_funct3 == F3_BU) ? {24'h0, w_byte} :
                    (i_funct3 == F3_H)  ? {{16{w_half[15]}}, w_half} :
                    (i_funct3 == F3_HU) ? {16'h0, w_half} : i_word;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data memory with fixed access latency, byte-enable
// stores, extended loads and error reporting for misaligned/out-of-range/illegal accesses.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY > 0 ? LATENCY - 1 : 0);

    mem_state_t     r_state, w_next;
    logic [CW-1:0]  r_cnt;
    logic           r_write;
    logic [31:0]    r_addr, r_wdata, r_rdata;
    logic [2:0]     r_funct3;
    logic           r_err;
    logic [31:0]    r_mem [DEPTH_WORDS];

    logic           w_accept, w_exec, w_write, w_mis, w_oor, w_ill, w_err;
    logic [31:0]    w_addr, w_wdata, w_wd, w_ld;
    logic [2:0]     w_funct3;
    logic [3:0]     w_be;
    logic [AW-1:0]  w_idx;

    assign w_accept = r_state == IDLE && req_valid;
    // With zero latency the access executes on the accept edge, straight from the request port.
    assign w_exec   = rst && ((r_state == WAIT && r_cnt == '0) || (LATENCY == 0 && w_accept));
    assign w_write  = (r_state == IDLE) ? req_write  : r_write;
    assign w_addr   = (r_state == IDLE) ? req_addr   : r_addr;
    assign w_funct3 = (r_state == IDLE) ? req_funct3 : r_funct3;
    assign w_wdata  = (r_state == IDLE) ? req_wdata  : r_wdata;

    assign w_mis = ((w_funct3 == F3_H || w_funct3 == F3_HU) && w_addr[0]) ||
                   (w_funct3 == F3_W && w_addr[1:0] != 2'b00);
    assign w_oor = w_addr[31:2] >= 30'(DEPTH_WORDS);
    assign w_ill = w_write ? !(w_funct3 inside {F3_B, F3_H, F3_W}) :
                             !(w_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    assign w_err = w_mis || w_oor || w_ill;
    assign w_idx = w_addr[AW+1:2];

    assign w_be = (w_funct3 == F3_B) ? 4'b0001 << w_addr[1:0] :
                  (w_funct3 == F3_H) ? (w_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_wd = (w_funct3 == F3_B) ? {4{w_wdata[7:0]}} :
                  (w_funct3 == F3_H) ? {2{w_wdata[15:0]}} : w_wdata;

    load_formatter u_fmt (
        .i_word   (r_mem[w_idx]),
        .i_offset (w_addr[1:0]),
        .i_funct3 (w_funct3),
        .o_data   (w_ld)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = req_valid ? (LATENCY > 0 ? WAIT : RESP) : IDLE;
            WAIT:    w_next = (r_cnt == '0) ? RESP : WAIT;
            RESP:    w_next = rsp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_funct3 <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt    <= CNT_LOAD;
                r_write  <= req_write;
                r_addr   <= req_addr;
                r_funct3 <= req_funct3;
                r_wdata  <= req_wdata;
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_exec) begin
                r_rdata <= (w_err || w_write) ? '0 : w_ld;
                r_err   <= w_err;
            end
        end
    end

    // Storage is deliberately not reset; w_exec is already gated by rst.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (w_exec && w_write && !w_err && w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
    end

    assign req_ready = r_state == IDLE;
    assign rsp_valid = r_state == RESP;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
endmodule
